// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one off-chip memory port between the I-cache and D-cache miss paths.
// One block transaction is in flight at a time; every output is a registered copy of the next-state logic.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_d;
    logic              w_last_d_nxt;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_pick_d;
    logic              w_mem_read_nxt;
    logic              w_mem_write_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic [DATA_W-1:0] w_i_rdata_nxt;
    logic [DATA_W-1:0] w_d_rdata_nxt;
    logic              w_i_ready_nxt;
    logic              w_d_ready_nxt;

    assign w_i_req  = i_read;
    assign w_d_req  = d_read | d_write;
    // On a tie the requester that was not served last wins; r_last_d=0 after reset lets D win first.
    assign w_pick_d = w_d_req && (!w_i_req || !r_last_d);

    always_comb begin
        w_state_nxt     = r_state;
        w_last_d_nxt    = r_last_d;
        w_mem_read_nxt  = mem_read;
        w_mem_write_nxt = mem_write;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_i_rdata_nxt   = i_rdata;
        w_d_rdata_nxt   = d_rdata;
        w_i_ready_nxt   = 1'b0;
        w_d_ready_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_state_nxt     = GNT_D;
                    w_mem_write_nxt = d_write;
                    w_mem_read_nxt  = !d_write;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_write ? d_wdata : '0;
                end else if (w_i_req) begin
                    w_state_nxt     = GNT_I;
                    w_mem_read_nxt  = 1'b1;
                    w_mem_write_nxt = 1'b0;
                    w_mem_addr_nxt  = i_addr;
                    w_mem_wdata_nxt = '0;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    w_state_nxt     = RESP;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_i_rdata_nxt   = mem_rdata;
                    w_i_ready_nxt   = 1'b1;
                    w_last_d_nxt    = 1'b0;
                end
            end
            GNT_D: begin
                // A write-back returns no block, so the D-cache sees zero data for it.
                if (mem_ready) begin
                    w_state_nxt     = RESP;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_d_rdata_nxt   = mem_write ? '0 : mem_rdata;
                    w_d_ready_nxt   = 1'b1;
                    w_last_d_nxt    = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last_d  <= w_last_d_nxt;
            mem_read  <= w_mem_read_nxt;
            mem_write <= w_mem_write_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            i_rdata   <= w_i_rdata_nxt;
            d_rdata   <= w_d_rdata_nxt;
            i_ready   <= w_i_ready_nxt;
            d_ready   <= w_d_ready_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester agents, a latency-configurable memory responder,
// and a transaction-level round-robin model that predicts grant order and returned data.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    typedef struct {bit wr; bit both; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
    typedef struct {bit isD; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] rdata;} txn_t;
    typedef struct {int cyc; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} grant_t;
    typedef struct {int cyc; bit isD; logic [DW-1:0] data;} resp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    req_t   iQ[$], dQ[$], stI[$], stD[$];
    grant_t grantLog[$];
    resp_t  respLog[$];
    txn_t   expQ[$];
    int gBase = 0, rBase = 0;
    bit respEnable = 1'b1, spurious = 1'b0, abortAll = 1'b0, scramble = 1'b0;
    int memLat = 2;
    logic [DW-1:0] modelMem [logic [AW-1:0]];
    bit modelLastD = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Contents of never-written memory blocks; 0x10 holds the all-A5 pattern.
    function automatic logic [DW-1:0] initData(input logic [AW-1:0] a);
        if (a == 28'h10) return {16{8'hA5}};
        return {4{a ^ 28'h5A5A5A5, 4'h3}};
    endfunction

    function automatic req_t mkReq(input bit wr, input bit both, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_t r;
        r.wr = wr; r.both = both; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: answers a strobe memLat cycles after it first appears.
    initial begin
        logic [DW-1:0] respMem [logic [AW-1:0]];
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (spurious) begin
                mem_ready = 1'b1;
                mem_rdata = {4{$urandom}};
            end else if (respEnable && (mem_read || mem_write)) begin
                if (!busy) begin busy = 1'b1; cnt = memLat; end
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    busy = 1'b0;
                    if (mem_write) begin
                        respMem[mem_addr] = mem_wdata;
                        mem_rdata = {4{$urandom}};
                    end else begin
                        mem_rdata = respMem.exists(mem_addr) ? respMem[mem_addr] : initData(mem_addr);
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    // I-cache agent: holds each queued request until i_ready, drops it in the RESP cycle.
    initial begin
        int iIdx;
        iIdx = 0;
        forever begin
            @(negedge clk);
            if (abortAll) begin
                i_read = 1'b0; iIdx = iQ.size();
            end else if (i_read && i_ready) begin
                i_read = 1'b0; iIdx++;
            end else if (!i_read && iIdx < iQ.size()) begin
                i_read = 1'b1; i_addr = iQ[iIdx].addr;
            end else if (i_read && scramble && mem_read) begin
                i_addr = AW'($urandom);
            end
        end
    end

    // D-cache agent; 'both' raises d_read alongside d_write for a write-back.
    initial begin
        int dIdx;
        dIdx = 0;
        forever begin
            @(negedge clk);
            if (abortAll) begin
                d_read = 1'b0; d_write = 1'b0; dIdx = dQ.size();
            end else if ((d_read || d_write) && d_ready) begin
                d_read = 1'b0; d_write = 1'b0; dIdx++;
            end else if (!(d_read || d_write) && dIdx < dQ.size()) begin
                d_write = dQ[dIdx].wr;
                d_read  = !dQ[dIdx].wr || dQ[dIdx].both;
                d_addr  = dQ[dIdx].addr;
                d_wdata = dQ[dIdx].wdata;
            end
        end
    end

    // Monitor: logs each new strobe and each ready pulse, tallies protocol violations.
    initial begin
        grant_t g;
        resp_t  r;
        bit prevStrobe, prevReady;
        prevStrobe = 1'b0;
        prevReady = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ((mem_read || mem_write) && !prevStrobe) begin
                    g.cyc = cyc; g.wr = mem_write; g.addr = mem_addr; g.wdata = mem_wdata;
                    grantLog.push_back(g);
                end
                if (i_ready) begin r.cyc = cyc; r.isD = 1'b0; r.data = i_rdata; respLog.push_back(r); end
                if (d_ready) begin r.cyc = cyc; r.isD = 1'b1; r.data = d_rdata; respLog.push_back(r); end
                if (mem_read && mem_write) viol++;
                if (i_ready && d_ready) viol++;
                if ((i_ready || d_ready) && prevReady) viol++;
            end
            prevStrobe = mem_read || mem_write;
            prevReady = i_ready || d_ready;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: alternate whenever both sides have work, else serve whoever has work.
    task automatic submit();
        int ii, dd;
        bit takeD;
        txn_t t;
        tick();
        expQ.delete();
        gBase = grantLog.size();
        rBase = respLog.size();
        ii = 0;
        dd = 0;
        while (ii < stI.size() || dd < stD.size()) begin
            takeD = (dd < stD.size()) && (ii >= stI.size() || !modelLastD);
            if (takeD) begin
                t.isD = 1'b1; t.wr = stD[dd].wr; t.addr = stD[dd].addr;
                t.wdata = stD[dd].wr ? stD[dd].wdata : '0;
                if (stD[dd].wr) begin
                    modelMem[t.addr] = t.wdata;
                    t.rdata = '0;
                end else begin
                    t.rdata = modelMem.exists(t.addr) ? modelMem[t.addr] : initData(t.addr);
                end
                dd++;
            end else begin
                t.isD = 1'b0; t.wr = 1'b0; t.addr = stI[ii].addr; t.wdata = '0;
                t.rdata = modelMem.exists(t.addr) ? modelMem[t.addr] : initData(t.addr);
                ii++;
            end
            modelLastD = takeD;
            expQ.push_back(t);
        end
        foreach (stI[k]) iQ.push_back(stI[k]);
        foreach (stD[k]) dQ.push_back(stD[k]);
        stI.delete();
        stD.delete();
    endtask

    task automatic waitDone(input int n, input int budget, output bit ok);
        int w;
        w = 0;
        while (respLog.size() < rBase + n && w < budget) begin
            @(negedge clk);
            w++;
        end
        ok = (respLog.size() >= rBase + n);
    endtask

    task automatic test_reset();
        bit ok;
        int rel;
        repeat (2) tick();
        stD.push_back(mkReq(1'b1, 1'b0, 28'h50, {4{32'hCAFE_0001}}));
        stI.push_back(mkReq(1'b0, 1'b0, 28'h60, '0));
        memLat = 2;
        submit();
        repeat (3) tick();
        checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, i_rdata, i_ready, d_rdata, d_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rd=%0b wr=%0b addr=%h ir=%0b dr=%0b, want all 0", mem_read, mem_write, mem_addr, i_ready, d_ready);
        end
        rst = 1'b0;
        rel = cyc;
        waitDone(2, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL reset_timeout: got %0d readies, want 2", respLog.size() - rBase); end
        else begin
            checks++;
            if (grantLog[gBase].cyc !== rel + 1) begin
                errors++; $display("[TB] FAIL reset_first_strobe: got cycle %0d, want %0d", grantLog[gBase].cyc, rel + 1);
            end
            for (int k = 0; k < expQ.size(); k++) begin
                checks++;
                if (respLog[rBase+k].isD !== expQ[k].isD || grantLog[gBase+k].wr !== expQ[k].wr || grantLog[gBase+k].addr !== expQ[k].addr ||
                    ((expQ[k].wr || !expQ[k].isD) && grantLog[gBase+k].wdata !== expQ[k].wdata)) begin
                    errors++;
                    $display("[TB] FAIL reset_order txn %0d: got d=%0b wr=%0b addr=%h, want d=%0b wr=%0b addr=%h", k, respLog[rBase+k].isD, grantLog[gBase+k].wr, grantLog[gBase+k].addr, expQ[k].isD, expQ[k].wr, expQ[k].addr);
                end
                checks++;
                if (respLog[rBase+k].data !== expQ[k].rdata) begin
                    errors++; $display("[TB] FAIL reset_rdata txn %0d: got %h want %h", k, respLog[rBase+k].data, expQ[k].rdata);
                end
            end
        end
    endtask

    task automatic test_i_read();
        bit ok;
        int t;
        stI.push_back(mkReq(1'b0, 1'b0, 28'h10, '0));
        memLat = 4;
        submit();
        t = cyc;
        waitDone(1, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL iread_timeout: got %0d readies, want 1", respLog.size() - rBase); end
        else begin
            checks++;
            if (grantLog[gBase].cyc !== t + 1 || grantLog[gBase].wr !== 1'b0 || grantLog[gBase].addr !== 28'h10 || grantLog[gBase].wdata !== '0) begin
                errors++; $display("[TB] FAIL iread_strobe: got cyc=%0d wr=%0b addr=%h, want cyc=%0d wr=0 addr=0000010", grantLog[gBase].cyc, grantLog[gBase].wr, grantLog[gBase].addr, t + 1);
            end
            checks++;
            if (respLog[rBase].cyc !== grantLog[gBase].cyc + 5 || respLog[rBase].isD !== 1'b0) begin
                errors++; $display("[TB] FAIL iread_ready: got cyc=%0d d=%0b, want cyc=%0d d=0", respLog[rBase].cyc, respLog[rBase].isD, grantLog[gBase].cyc + 5);
            end
            checks++;
            if (respLog[rBase].data !== {16{8'hA5}}) begin
                errors++; $display("[TB] FAIL iread_rdata: got %h want all A5", respLog[rBase].data);
            end
        end
    endtask

    task automatic test_d_write_read();
        bit ok;
        stD.push_back(mkReq(1'b1, 1'b1, 28'h20, {4{32'h1234_5678}}));
        stD.push_back(mkReq(1'b0, 1'b0, 28'h30, '0));
        stD.push_back(mkReq(1'b0, 1'b0, 28'h20, '0));
        stI.push_back(mkReq(1'b0, 1'b0, 28'h40, '0));
        stI.push_back(mkReq(1'b0, 1'b0, 28'h50, '0));
        memLat = 1;
        submit();
        waitDone(5, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL dwr_timeout: got %0d readies, want 5", respLog.size() - rBase); end
        else begin
            for (int k = 0; k < expQ.size(); k++) begin
                checks++;
                if (respLog[rBase+k].isD !== expQ[k].isD || grantLog[gBase+k].wr !== expQ[k].wr || grantLog[gBase+k].addr !== expQ[k].addr ||
                    ((expQ[k].wr || !expQ[k].isD) && grantLog[gBase+k].wdata !== expQ[k].wdata)) begin
                    errors++;
                    $display("[TB] FAIL dwr_order txn %0d: got d=%0b wr=%0b addr=%h wdata=%h, want d=%0b wr=%0b addr=%h wdata=%h", k, respLog[rBase+k].isD, grantLog[gBase+k].wr, grantLog[gBase+k].addr, grantLog[gBase+k].wdata, expQ[k].isD, expQ[k].wr, expQ[k].addr, expQ[k].wdata);
                end
                checks++;
                if (respLog[rBase+k].data !== expQ[k].rdata) begin
                    errors++; $display("[TB] FAIL dwr_rdata txn %0d: got %h want %h", k, respLog[rBase+k].data, expQ[k].rdata);
                end
            end
        end
    endtask

    task automatic test_alternation();
        bit ok;
        for (int k = 0; k < 3; k++) begin
            stD.push_back(mkReq(1'b0, 1'b0, AW'(32'h200 + 16 * k), '0));
            stI.push_back(mkReq(1'b0, 1'b0, AW'(32'h300 + 16 * k), '0));
        end
        memLat = 0;
        submit();
        waitDone(6, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL alt_timeout: got %0d readies, want 6", respLog.size() - rBase); end
        else begin
            for (int k = 0; k < expQ.size(); k++) begin
                checks++;
                if (respLog[rBase+k].isD !== expQ[k].isD || grantLog[gBase+k].addr !== expQ[k].addr || respLog[rBase+k].data !== expQ[k].rdata) begin
                    errors++;
                    $display("[TB] FAIL alt_txn %0d: got d=%0b addr=%h data=%h, want d=%0b addr=%h data=%h", k, respLog[rBase+k].isD, grantLog[gBase+k].addr, respLog[rBase+k].data, expQ[k].isD, expQ[k].addr, expQ[k].rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        int w;
        respEnable = 1'b0;
        stD.push_back(mkReq(1'b0, 1'b0, 28'h70, '0));
        submit();
        w = 0;
        while (!mem_read && w < 10) begin @(negedge clk); w++; end
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL midrst_grant: got mem_read=%0b, want 1", mem_read); end
        tick();
        rst = 1'b1;
        abortAll = 1'b1;
        tick();
        checks++;
        if ({mem_read, mem_write, mem_addr, i_ready, d_ready} !== '0) begin
            errors++; $display("[TB] FAIL midrst_outputs: got rd=%0b wr=%0b addr=%h ir=%0b dr=%0b, want all 0", mem_read, mem_write, mem_addr, i_ready, d_ready);
        end
        rst = 1'b0;
        abortAll = 1'b0;
        modelLastD = 1'b0;
        tick();
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (respLog.size() !== rBase || grantLog.size() !== gBase + 1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_after: got readies=%0d grants=%0d rd=%0b wr=%0b, want 0 1 0 0", respLog.size() - rBase, grantLog.size() - gBase, mem_read, mem_write);
        end
        respEnable = 1'b1;
    endtask

    task automatic test_spurious_and_addr();
        int gsz, rsz, w, bad;
        gsz = grantLog.size();
        rsz = respLog.size();
        tick();
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (respLog.size() !== rsz || grantLog.size() !== gsz) begin
            errors++; $display("[TB] FAIL spurious_idle: got readies=%0d grants=%0d, want 0 0", respLog.size() - rsz, grantLog.size() - gsz);
        end
        scramble = 1'b1;
        memLat = 3;
        stI.push_back(mkReq(1'b0, 1'b0, 28'h88, '0));
        submit();
        w = 0;
        bad = 0;
        while (respLog.size() < rBase + 1 && w < 60) begin
            @(negedge clk);
            w++;
            if (mem_read && mem_addr !== 28'h88) bad++;
        end
        scramble = 1'b0;
        checks++;
        if (respLog.size() < rBase + 1) begin errors++; $display("[TB] FAIL addrchg_timeout: got 0 readies, want 1"); end
        else begin
            checks++;
            if (bad !== 0 || grantLog[gBase].addr !== 28'h88) begin
                errors++; $display("[TB] FAIL addrchg_hold: got %0d bad cycles, grant addr %h, want 0 and 0000088", bad, grantLog[gBase].addr);
            end
            checks++;
            if (respLog[rBase].data !== expQ[0].rdata) begin
                errors++; $display("[TB] FAIL addrchg_rdata: got %h want %h", respLog[rBase].data, expQ[0].rdata);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int nI, nD, lat;
        for (int r = 0; r < 10; r++) begin
            nI = $urandom_range(0, 3);
            nD = $urandom_range(nI == 0 ? 1 : 0, 3);
            lat = $urandom_range(0, 4);
            memLat = lat;
            for (int k = 0; k < nI; k++) stI.push_back(mkReq(1'b0, 1'b0, AW'(32'h100 + 16 * $urandom_range(0, 7)), '0));
            for (int k = 0; k < nD; k++)
                stD.push_back(mkReq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'(32'h100 + 16 * $urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom}));
            submit();
            waitDone(nI + nD, (nI + nD) * (lat + 4) + 20, ok);
            checks++;
            if (!ok) begin errors++; $display("[TB] FAIL rand_timeout round %0d: got %0d readies, want %0d", r, respLog.size() - rBase, nI + nD); end
            else begin
                for (int k = 0; k < expQ.size(); k++) begin
                    checks++;
                    if (respLog[rBase+k].isD !== expQ[k].isD || grantLog[gBase+k].wr !== expQ[k].wr || grantLog[gBase+k].addr !== expQ[k].addr ||
                        ((expQ[k].wr || !expQ[k].isD) && grantLog[gBase+k].wdata !== expQ[k].wdata) || respLog[rBase+k].data !== expQ[k].rdata) begin
                        errors++;
                        $display("[TB] FAIL rand_txn r%0d k%0d: got d=%0b wr=%0b addr=%h data=%h, want d=%0b wr=%0b addr=%h data=%h", r, k, respLog[rBase+k].isD, grantLog[gBase+k].wr, grantLog[gBase+k].addr, respLog[rBase+k].data, expQ[k].isD, expQ[k].wr, expQ[k].addr, expQ[k].rdata);
                    end
                    checks++;
                    if (respLog[rBase+k].cyc - grantLog[gBase+k].cyc !== lat + 1) begin
                        errors++; $display("[TB] FAIL rand_latency r%0d k%0d: got %0d cycles, want %0d", r, k, respLog[rBase+k].cyc - grantLog[gBase+k].cyc, lat + 1);
                    end
                    if (k > 0) begin
                        checks++;
                        if (grantLog[gBase+k].cyc - respLog[rBase+k-1].cyc !== 2) begin
                            errors++; $display("[TB] FAIL rand_turnaround r%0d k%0d: got %0d cycles, want 2", r, k, grantLog[gBase+k].cyc - respLog[rBase+k-1].cyc);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin
            errors++; $display("[TB] FAIL invariants: got %0d protocol violations, want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write_read();
        test_alternation();
        test_reset_mid_grant();
        test_spurious_and_addr();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache miss path and the D-cache miss/write-back path.
- Sits between both cache controllers and the memory model.
- Serializes one block transaction at a time and arbitrates simultaneous requests round-robin.
- Returns per-requester ready pulses; the caches convert these into the stall that freezes the pipeline registers.

Parameters:
- ADDR_W, 28, block address width, shared by requesters and memory.
- DATA_W, 128, block data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_read  in  1  I-cache block read request; held until i_ready.
- i_addr  in  ADDR_W  I-cache block address.
- i_rdata  out  DATA_W  block returned to I-cache; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache block read request; held until d_ready.
- d_write  in  1  D-cache block write-back request; held until d_ready.
- d_addr  in  ADDR_W  D-cache block address.
- d_wdata  in  DATA_W  D-cache write-back block.
- d_rdata  out  DATA_W  block returned to D-cache; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory block address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completion pulse.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at an edge): state=IDLE, last_grant=I.
  - All outputs are 0: strobes, addr, wdata, rdata and ready.
  - Reset mid-transaction abandons the transaction; no ready pulse is issued for it.
- States:
  - IDLE: no grant.
  - GNT_I: serving I-cache.
  - GNT_D: serving D-cache.
  - RESP: one cycle in which the ready pulse is driven.
- IDLE transitions:
  - Neither requesting: stay in IDLE.
  - Only I requesting (i_read): go to GNT_I.
  - Only D requesting (d_read|d_write): go to GNT_D.
  - Both requesting: grant the requester that is not last_grant. After reset, D wins the first tie.
  - On entering a GNT state: latch addr/wdata onto mem_* and set the strobe.
  - Latency: request in IDLE at cycle t gives strobe high at t+1.
- D op select: d_write=1 issues a write (mem_write=1, mem_wdata=d_wdata). Otherwise a read. d_write has priority if both d_read and d_write are high.
- I op: always a read; mem_wdata is held at 0.
- GNT_x: strobe, addr and wdata stay stable until mem_ready.
  - On mem_ready=1: clear strobes, capture mem_rdata into x_rdata, set x_ready=1, update last_grant=x, go to RESP.
- RESP: ready is high for exactly this cycle.
  - The requester drops its request in this cycle.
  - Next state is IDLE with ready=0. The held request is never re-granted.
- x_rdata:
  - Holds its captured value after the pulse until the next capture or reset.
  - d_rdata after a write transaction is 0.
- Minimum turnaround: 3 cycles plus memory latency per transaction. Back-to-back requests from the same requester are legal after RESP.
- Requests that appear while another grant is active wait. No request is ever dropped.
- Max wait for a requester is one full transaction of the other requester, because round-robin prevents starvation.
- mem_ready outside GNT states is ignored.
- Requester address/data changes during a grant are ignored, since the values were latched at grant.
- Exactly one of mem_read and mem_write is high in any cycle, or neither.
- i_ready and d_ready are never high together.

Test Plan:
- Reset with both requests high; deassert rst at cycle 0 -> D granted first (mem_write or mem_read at cycle 1), I served after D's RESP; all outputs 0 during reset.
- I read only, i_addr=0x0000010; memory returns mem_ready 4 cycles after the strobe with rdata=0xA5..A5 -> mem_read=1 with mem_addr=0x0000010 from cycle 1, i_ready pulses one cycle after mem_ready with i_rdata=0xA5..A5, then IDLE.
- D write-back (d_addr=0x0000020, d_wdata=0x1234...) followed immediately by a D read (0x0000030) while I requests continuously -> order is D-write, I-read, D-read; each ready is one cycle wide.
- Persistent simultaneous requests for 6 transactions -> grants alternate D, I, D, I, D, I.
- Assert rst during GNT_D before mem_ready -> next cycle all strobes and readies are 0; the later mem_ready pulse is ignored; no d_ready is issued.
- Spurious mem_ready in IDLE, and address changes mid-grant -> no ready pulse; mem_addr keeps its latched value.
